// File: rtl/vec_pkg.sv
// Shared vector-unit types: register write/read opcodes and the write-arbiter FSM states.
package vec_pkg;

    typedef enum logic [1:0] {
        DISABLE = 2'd0,
        VEC     = 2'd1,
        SCALAR  = 2'd2
    } VecDataWriteOp_t;

    typedef enum logic [1:0] {
        RD_DISABLE = 2'd0,
        RD_VEC     = 2'd1,
        RD_SCALAR  = 2'd2
    } VecDataReadOp_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } VecArbState_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request after
// the pointer, in cyclic order. Returns the grant one-hot, encoded, and an any flag.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    int w_idx;

    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        w_idx = 0;
        // Offset NUM_REQ wraps back to the pointer itself, so it is searched last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(pointer) + k) % NUM_REQ;
            if (!any && req[w_idx]) begin
                any          = 1'b1;
                grant[w_idx] = 1'b1;
                id           = ID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/vec_reg_write_arbiter.sv
// Round-robin arbiter for the single write port of a vector register; issues VEC
// writes and SCALAR bursts. Define VEC_REG_ARB_PRIORITY_EN to give requester 0 priority.
module vec_reg_write_arbiter
    import vec_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
    parameter int REQ_ID_SIZE     = $clog2(NUM_REQ)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  VecDataWriteOp_t            req_op    [NUM_REQ],
    input  logic [WIDTH_ADDR_SIZE-1:0] req_index [NUM_REQ],
    input  logic [WIDTH_ADDR_SIZE:0]   req_len   [NUM_REQ],
    input  logic                       stall,
    output VecDataWriteOp_t            write_op,
    output logic [WIDTH_ADDR_SIZE-1:0] write_param,
    output logic [REQ_ID_SIZE-1:0]     grant_id,
    output logic                       busy,
    output logic                       done,
    output VecArbState_t               state_dbg
);

    localparam logic [WIDTH_ADDR_SIZE:0] LEN_MAX = (WIDTH_ADDR_SIZE+1)'(WIDTH);
    localparam logic [WIDTH_ADDR_SIZE:0] ONE     = (WIDTH_ADDR_SIZE+1)'(1);

    // Handshake: req_ready[i] is asserted only for the winner of an open accept
    // slot; the request is taken (and latched) at the rising edge where
    // req_valid[i] and req_ready[i] are both high.
    VecArbState_t                 r_state, w_state_nx;
    logic [REQ_ID_SIZE-1:0]       r_ptr, w_ptr_nx;
    logic [WIDTH_ADDR_SIZE:0]     r_remain, w_remain_nx;
    VecDataWriteOp_t              w_op_nx;
    logic [WIDTH_ADDR_SIZE-1:0]   w_param_nx;
    logic [REQ_ID_SIZE-1:0]       w_gid_nx;
    logic                         w_done_nx;

    logic [NUM_REQ-1:0]           w_arb_req, w_rr_grant, w_win_grant;
    logic [REQ_ID_SIZE-1:0]       w_rr_id, w_win_id;
    logic                         w_rr_any, w_win_any;
    VecDataWriteOp_t              w_sel_op;
    logic [WIDTH_ADDR_SIZE:0]     w_sel_len, w_len_c, w_idx_ext, w_param_ext;
    logic                         w_last, w_slot, w_acc, w_fires;

    always_comb begin
        w_arb_req = req_valid;
`ifdef VEC_REG_ARB_PRIORITY_EN
        w_arb_req[0] = 1'b0;
`endif
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(REQ_ID_SIZE)) u_rr (
        .req     (w_arb_req),
        .pointer (r_ptr),
        .grant   (w_rr_grant),
        .id      (w_rr_id),
        .any     (w_rr_any)
    );

    always_comb begin
        w_win_grant = w_rr_grant;
        w_win_id    = w_rr_id;
        w_win_any   = w_rr_any;
`ifdef VEC_REG_ARB_PRIORITY_EN
        if (req_valid[0]) begin
            w_win_grant = NUM_REQ'(1);
            w_win_id    = '0;
            w_win_any   = 1'b1;
        end
`endif
    end

    always_comb begin
        w_sel_op  = req_op[w_win_id];
        w_sel_len = req_len[w_win_id];
        w_len_c   = (w_sel_len > LEN_MAX) ? LEN_MAX : w_sel_len;
        // An index below 2**WIDTH_ADDR_SIZE is always below 2*WIDTH, so one subtract is a full mod.
        w_idx_ext = {1'b0, req_index[w_win_id]};
        if (w_idx_ext >= LEN_MAX) w_idx_ext = w_idx_ext - LEN_MAX;
        w_param_ext = {1'b0, write_param} + ONE;
        if (w_param_ext == LEN_MAX) w_param_ext = '0;

        w_last    = (r_remain == '0);
        w_slot    = !stall && ((r_state == IDLE) || w_last);
        w_acc     = w_slot && w_win_any;
        req_ready = w_acc ? w_win_grant : '0;
        w_fires   = (w_sel_op == VEC) || ((w_sel_op == SCALAR) && (w_len_c != '0));
    end

    always_comb begin
        w_state_nx  = r_state;
        w_ptr_nx    = r_ptr;
        w_remain_nx = r_remain;
        w_op_nx     = DISABLE;
        w_param_nx  = write_param;
        w_gid_nx    = grant_id;
        w_done_nx   = 1'b0;
        if (w_acc) w_ptr_nx = w_win_id;
        if (!stall) begin
            if ((r_state == ISSUE) && !w_last) begin
                w_op_nx     = SCALAR;
                w_param_nx  = w_param_ext[WIDTH_ADDR_SIZE-1:0];
                w_remain_nx = r_remain - ONE;
                w_done_nx   = (r_remain == ONE);
            end else if (w_acc && w_fires) begin
                w_state_nx = ISSUE;
                w_op_nx    = w_sel_op;
                w_gid_nx   = w_win_id;
                if (w_sel_op == SCALAR) begin
                    w_param_nx  = w_idx_ext[WIDTH_ADDR_SIZE-1:0];
                    w_remain_nx = w_len_c - ONE;
                    w_done_nx   = (w_len_c == ONE);
                end else begin
                    w_param_nx  = '0;
                    w_remain_nx = '0;
                    w_done_nx   = 1'b1;
                end
            end else begin
                w_state_nx  = IDLE;
                w_remain_nx = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= REQ_ID_SIZE'(NUM_REQ - 1);
            r_remain    <= '0;
            write_op    <= DISABLE;
            write_param <= '0;
            grant_id    <= '0;
            done        <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ptr       <= w_ptr_nx;
            r_remain    <= w_remain_nx;
            write_op    <= w_op_nx;
            write_param <= w_param_nx;
            grant_id    <= w_gid_nx;
            done        <= w_done_nx;
        end
    end

    assign busy      = (r_state != IDLE);
    assign state_dbg = r_state;

endmodule

// File: tb/tb_vec_reg_write_arbiter.sv
// Directed bench for vec_reg_write_arbiter (NUM_REQ=4, WIDTH=128).
module tb_vec_reg_write_arbiter;
    import vec_pkg::*;

    logic            clock = 1'b0;
    logic            reset;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    VecDataWriteOp_t req_op    [4];
    logic [6:0]      req_index [4];
    logic [7:0]      req_len   [4];
    logic            stall;
    VecDataWriteOp_t write_op;
    logic [6:0]      write_param;
    logic [1:0]      grant_id;
    logic            busy;
    logic            done;
    VecArbState_t    state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    vec_reg_write_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_index   (req_index),
        .req_len     (req_len),
        .stall       (stall),
        .write_op    (write_op),
        .write_param (write_param),
        .grant_id    (grant_id),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input VecDataWriteOp_t op, input logic [6:0] idx, input logic [7:0] len);
        req_valid[i] = 1'b1;
        req_op[i]    = op;
        req_index[i] = idx;
        req_len[i]   = len;
    endtask

    task automatic clr_req();
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            req_op[i]    = DISABLE;
            req_index[i] = '0;
            req_len[i]   = '0;
        end
    endtask

    task automatic chk_beat(input string tag, input VecDataWriteOp_t op, input logic [6:0] param,
                            input logic [1:0] gid, input logic dn, input logic bsy);
        chk({tag, "_op"},    write_op,    op);
        chk({tag, "_param"}, write_param, param);
        chk({tag, "_gid"},   grant_id,    gid);
        chk({tag, "_done"},  done,        dn);
        chk({tag, "_busy"},  busy,        bsy);
    endtask

    initial begin
        int beats;
        int last_param;
        bit got_done;

        reset = 1'b1;
        stall = 1'b0;
        clr_req();
        tick();
        tick();
        chk_beat("reset", DISABLE, 7'd0, 2'd0, 1'b0, 1'b0);
        chk("reset_ready", req_ready, 4'b0000);
        reset = 1'b0;
        tick();

        // Reset mid-burst: req1 SCALAR idx 20 len 8, reset on the third beat.
        set_req(1, SCALAR, 7'd20, 8'd8);
        #1 chk("t1_ready", req_ready, 4'b0010);
        tick();
        clr_req();
        chk_beat("t1_b0", SCALAR, 7'd20, 2'd1, 1'b0, 1'b1);
        tick();
        chk("t1_b1_param", write_param, 7'd21);
        tick();
        chk("t1_b2_param", write_param, 7'd22);
        reset = 1'b1;
        #1;
        chk("t1_rst_op", write_op, DISABLE);
        chk("t1_rst_busy", busy, 1'b0);
        tick();
        chk("t1_rst_hold_op", write_op, DISABLE);
        reset = 1'b0;
        set_req(0, VEC, 7'd0, 8'd0);
        set_req(1, VEC, 7'd0, 8'd0);
        #1 chk("t1_req0_first_ready", req_ready, 4'b0001);
        tick();
        clr_req();
        chk_beat("t1_req0_vec", VEC, 7'd0, 2'd0, 1'b1, 1'b1);
        tick();
        chk("t1_after_op", write_op, DISABLE);
        chk("t1_after_busy", busy, 1'b0);

        // Single VEC from requester 1.
        set_req(1, VEC, 7'd0, 8'd0);
        #1 chk("t2_ready", req_ready, 4'b0010);
        tick();
        clr_req();
        chk_beat("t2_vec", VEC, 7'd0, 2'd1, 1'b1, 1'b1);
        tick();
        chk("t2_after_op", write_op, DISABLE);
        chk("t2_after_done", done, 1'b0);

        // Burst wrap: 126,127,0,1.
        set_req(2, SCALAR, 7'd126, 8'd4);
        #1 chk("t3_ready", req_ready, 4'b0100);
        tick();
        clr_req();
        chk_beat("t3_b0", SCALAR, 7'd126, 2'd2, 1'b0, 1'b1);
        tick();
        chk_beat("t3_b1", SCALAR, 7'd127, 2'd2, 1'b0, 1'b1);
        tick();
        chk_beat("t3_b2", SCALAR, 7'd0, 2'd2, 1'b0, 1'b1);
        tick();
        chk_beat("t3_b3", SCALAR, 7'd1, 2'd2, 1'b1, 1'b1);
        tick();
        chk("t3_after_op", write_op, DISABLE);
        chk("t3_after_busy", busy, 1'b0);

        // Fairness: pointer sits at 2, so the order is 3,0,1,2,3,0,1,2 with no gaps.
        for (int i = 0; i < 4; i++) set_req(i, VEC, 7'd0, 8'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("t4_gid%0d", k), grant_id, 32'((3 + k) % 4));
            chk($sformatf("t4_op%0d", k), write_op, VEC);
        end
        clr_req();
        tick();
        chk("t4_after_op", write_op, DISABLE);

        // Stall: req3 SCALAR idx 10 len 4 -> 10,11,hold,hold,12,13.
        set_req(3, SCALAR, 7'd10, 8'd4);
        #1 chk("t5_ready", req_ready, 4'b1000);
        tick();
        clr_req();
        chk_beat("t5_b0", SCALAR, 7'd10, 2'd3, 1'b0, 1'b1);
        tick();
        chk_beat("t5_b1", SCALAR, 7'd11, 2'd3, 1'b0, 1'b1);
        stall = 1'b1;
        set_req(0, VEC, 7'd0, 8'd0);
        tick();
        chk_beat("t5_hold0", DISABLE, 7'd11, 2'd3, 1'b0, 1'b1);
        chk("t5_hold0_ready", req_ready, 4'b0000);
        tick();
        chk_beat("t5_hold1", DISABLE, 7'd11, 2'd3, 1'b0, 1'b1);
        stall = 1'b0;
        tick();
        chk_beat("t5_b2", SCALAR, 7'd12, 2'd3, 1'b0, 1'b1);
        chk("t5_b2_ready", req_ready, 4'b0000);
        tick();
        chk_beat("t5_b3", SCALAR, 7'd13, 2'd3, 1'b1, 1'b1);
        stall = 1'b1;
        #1 chk("t5_last_stall_ready", req_ready, 4'b0000);
        tick();
        chk_beat("t5_last_hold", DISABLE, 7'd13, 2'd3, 1'b0, 1'b1);
        stall = 1'b0;
        #1 chk("t5_resume_ready", req_ready, 4'b0001);
        tick();
        clr_req();
        chk_beat("t5_req0", VEC, 7'd0, 2'd0, 1'b1, 1'b1);
        tick();
        chk("t5_after_busy", busy, 1'b0);

        // Degenerate: SCALAR len 0 is accepted and advances the pointer to 3.
        set_req(3, SCALAR, 7'd5, 8'd0);
        #1 chk("t6_len0_ready", req_ready, 4'b1000);
        tick();
        clr_req();
        chk_beat("t6_len0", DISABLE, 7'd0, 2'd0, 1'b0, 1'b0);
        set_req(0, VEC, 7'd0, 8'd0);
        set_req(1, VEC, 7'd0, 8'd0);
        #1 chk("t6_ptr_ready", req_ready, 4'b0001);
        clr_req();
        #1 chk("t6_drop_ready", req_ready, 4'b0000);
        tick();
        chk("t6_drop_op", write_op, DISABLE);
        chk("t6_drop_busy", busy, 1'b0);
        // DISABLE op is accepted without a write; pointer moves to 1.
        set_req(1, DISABLE, 7'd0, 8'd0);
        #1 chk("t6_dis_ready", req_ready, 4'b0010);
        tick();
        clr_req();
        chk_beat("t6_dis", DISABLE, 7'd0, 2'd0, 1'b0, 1'b0);
        // Pointer at 1 with req0 and req2 valid.
        set_req(0, VEC, 7'd0, 8'd0);
        set_req(2, VEC, 7'd0, 8'd0);
`ifdef VEC_REG_ARB_PRIORITY_EN
        #1 chk("t6_prio_ready", req_ready, 4'b0001);
        tick();
        clr_req();
        chk_beat("t6_prio", VEC, 7'd0, 2'd0, 1'b1, 1'b1);
`else
        #1 chk("t6_rr_ready", req_ready, 4'b0100);
        tick();
        clr_req();
        chk_beat("t6_rr", VEC, 7'd0, 2'd2, 1'b1, 1'b1);
`endif
        tick();
        chk("t6_after_op", write_op, DISABLE);

        // Clamp: len 200 behaves as 128 beats, starting at 5 and ending at 4.
        set_req(1, SCALAR, 7'd5, 8'd200);
        #1 chk("t7_ready", req_ready, 4'b0010);
        tick();
        clr_req();
        chk("t7_first_param", write_param, 7'd5);
        beats = 0;
        last_param = 0;
        got_done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (write_op == SCALAR) beats++;
            if (done) begin
                last_param = int'(write_param);
                got_done = 1'b1;
                break;
            end
            tick();
        end
        chk("t7_done_seen", got_done, 1'b1);
        chk("t7_beats", beats, 128);
        chk("t7_last_param", last_param, 4);
        tick();
        chk("t7_after_op", write_op, DISABLE);
        chk("t7_after_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
